kpn_add_process: RTL

//  KPN process node downstream of queue_module: blocking-read one token from

---
 rtl/kpn_add_process.sv | 59 +++++
 1 files changed

// File: rtl/kpn_add_process.sv
// kpn_add_process: Kahn process node, pops one token from A then B, pushes their sum
// Ports: clk; rst_n (async, active low); a_data/a_empty/a_rd and b_data/b_empty/b_rd are
// show-ahead FIFO read sides; out_data/out_full/out_wr is the output FIFO write side;
// fire_count counts pushed results (wraps); ovf_sticky latches any signed overflow.
module kpn_add_process #(
   parameter int BITS_NUMBER = 16,
   parameter int SATURATE    = 0,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [BITS_NUMBER-1:0] a_data,
   input  logic                   a_empty,
   output logic                   a_rd,
   input  logic [BITS_NUMBER-1:0] b_data,
   input  logic                   b_empty,
   output logic                   b_rd,
   output logic [BITS_NUMBER-1:0] out_data,
   input  logic                   out_full,
   output logic                   out_wr,
   output logic [COUNT_WIDTH-1:0] fire_count,
   output logic                   ovf_sticky
);
   typedef enum logic [1:0] {RD_A, RD_B, CALC, WR} state_t;
   state_t state, state_nxt;
   logic [BITS_NUMBER-1:0] reg_a, reg_b, res;
   logic [BITS_NUMBER:0] sum;
   logic ovf;
   always_comb begin
      sum = {reg_a[BITS_NUMBER-1], reg_a} + {reg_b[BITS_NUMBER-1], reg_b};
      ovf = sum[BITS_NUMBER] ^ sum[BITS_NUMBER-1];
      // on overflow the extended sign bit gives the true sign: clamp towards it
      res = (SATURATE != 0 && ovf) ? {sum[BITS_NUMBER], {(BITS_NUMBER-1){~sum[BITS_NUMBER]}}}
                                   : sum[BITS_NUMBER-1:0];
      a_rd = rst_n && state == RD_A && !a_empty;
      b_rd = rst_n && state == RD_B && !b_empty;
      out_wr = rst_n && state == WR && !out_full;
      // states are encoded in firing order, so WR + 1 wraps back to RD_A
      state_nxt = (a_rd || b_rd || out_wr || state == CALC) ? state_t'(state + 2'd1) : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= RD_A;
         reg_a <= '0;
         reg_b <= '0;
         out_data <= '0;
         fire_count <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         state <= state_nxt;
         if (a_rd) reg_a <= a_data;
         if (b_rd) reg_b <= b_data;
         if (state == CALC) begin
            out_data <= res;
            ovf_sticky <= ovf_sticky | ovf;
         end
         if (out_wr) fire_count <= fire_count + 1'b1;
      end
endmodule
